fir_stream_sequencer: RTL and testbench
=======================================

Name: fir_stream_sequencer

Overview:
Sequences sample delivery into the free-running fir_filter datapath, which shifts on every clock and has no enable. It accepts samples over a valid/ready handshake and issues them on a programmable sample strobe, inserting zeros on non-strobe cycles (zero-stuffing). It flushes the delay line with zeros on request and emits a latency-aligned output-valid. It sits between the sample source and the fir_filter instance.

Parameters:
DATA_W, 8, sample width; matches FIR x_in/y_out width
TAPS, 4, FIR delay-line depth; sets flush length
LATENCY, 1, FIR input-to-output latency in clocks (>=1)
RATE_W, 8, width of rate_div

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
enable  in  1  level; 1 = run, 0 = stop via flush
rate_div  in  RATE_W  strobe period minus 1; sampled each cycle
flush_req  in  1  single-cycle pulse; flush delay line
s_valid  in  1  upstream sample valid
s_data  in  DATA_W  upstream sample
s_ready  out  1  upstream accept; combinational
fir_x  out  DATA_W  registered drive to FIR x_in
fir_y  in  DATA_W  from FIR y_out
m_valid  out  1  fir_y holds a sequenced result
m_data  out  DATA_W  equals fir_y (pass-through)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, tick=0, fir_x=0, valid pipe=0, flush_cnt=0. s_ready=0, m_valid=0, busy=0 while rst=0.
- States: IDLE, RUN, FLUSH. State is registered and encoded in 2 bits.
- IDLE: fir_x<=0 and s_ready=0. If enable=1, go to RUN on the next edge. flush_req is ignored.
- RUN:
  - tick counts 0..rate_div and wraps to 0. strobe = (tick==rate_div).
  - If rate_div changes so that tick>rate_div, tick wraps to 0 on the next edge without a strobe.
  - s_ready = strobe.
  - On strobe with s_valid=1: fir_x<=s_data.
  - On strobe with s_valid=0: underrun; fir_x<=0.
  - On non-strobe cycles: fir_x<=0.
- RUN exit: enable=0 or flush_req=1 -> FLUSH on the next edge. s_ready is forced to 0 in that same cycle, so no sample is accepted on the exit cycle. flush_req takes priority over a simultaneous strobe.
- FLUSH: fir_x<=0 and s_ready=0. flush_cnt counts TAPS+LATENCY cycles, then the state goes to IDLE. enable and flush_req are ignored during FLUSH.
- Valid pipe: a LATENCY-deep shift register whose input bit is (state==RUN or state==FLUSH) registered alongside fir_x. m_valid is the pipe's last stage, so it trails busy by LATENCY cycles.
- No downstream backpressure: m_valid/m_data are not stalled.
- Width rules:
  - tick is RATE_W bits.
  - flush_cnt is clog2(TAPS+LATENCY+1) bits.
  - No arithmetic on data.
- Reset mid-operation: returns to IDLE on the next edge. In-flight data is discarded and m_valid drops immediately.

Optional Feature:
Macro FIR_UNDERRUN_CNT_EN.
- Defined: adds output port underrun_cnt (16 bits). It increments on each RUN strobe where s_valid=0, saturates at 0xFFFF, and is cleared only by reset.
- Undefined: the port and counter are absent. Underrun behaviour (inject 0) is unchanged.

Test Plan:
1. Hold rst=0 for 5 cycles with enable=1, s_valid=1, s_data=100 -> s_ready=0, fir_x=0, m_valid=0, busy=0 throughout.
2. Release rst with rate_div=0, enable=1, s_valid=1, s_data=100 -> busy=1 one cycle later. s_ready=1 every RUN cycle; fir_x=100 from the edge after the first accept. m_valid=1 LATENCY(1) cycles after the first RUN cycle.
3. rate_div=3, s_valid=1, s_data=255 -> s_ready high 1 of every 4 cycles; fir_x pattern is 255,0,0,0 repeating. Changing rate_div to 1 mid-run gives pattern 255,0.
4. Macro defined, rate_div=1, s_valid=0 for 3 strobes -> fir_x=0 throughout and underrun_cnt=3. A following beat with s_data=50 drives fir_x=50 and underrun_cnt stays 3.
5. flush_req pulse in RUN coincident with a strobe and s_valid=1 -> s_ready=0 that cycle (sample not accepted). FLUSH holds fir_x=0 for exactly 5 cycles (TAPS+LATENCY), then IDLE with busy=0; m_valid falls 1 cycle after busy.
6. Assert rst=0 on the 2nd FLUSH cycle -> next edge gives IDLE, fir_x=0, m_valid=0. After release with enable=1 the block re-enters RUN normally and tick starts at 0.

Source files
------------

// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: zero-stuffing, flushing sample sequencer for a free-running FIR.
// Define FIR_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module fir_stream_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TAPS    = 4,
  parameter int LATENCY = 1,
  parameter int RATE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate_div,
  input  logic              flush_req,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] fir_x,
  input  logic [DATA_W-1:0] fir_y,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef FIR_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);
  localparam int FLUSH_N = TAPS + LATENCY;
  localparam int CNT_W = $clog2(FLUSH_N + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [RATE_W-1:0] tick, tick_nx;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_nx;
  logic [DATA_W-1:0] fir_x_nx;
  logic [LATENCY-1:0] vpipe;
  logic strobe, leave, take;
  assign strobe = tick == rate_div;
  assign leave = !enable || flush_req;
  // leaving RUN suppresses the strobe so nothing is accepted on the exit cycle
  assign take = state == RUN && strobe && !leave;
  assign s_ready = rst && take;
  assign busy = rst && state != IDLE;
  assign m_valid = rst && vpipe[LATENCY-1];
  assign m_data = fir_y;
  always_comb begin
    state_nx = state;
    tick_nx = '0;
    flush_cnt_nx = '0;
    fir_x_nx = '0;
    case (state)
      IDLE: state_nx = enable ? RUN : IDLE;
      RUN: begin
        state_nx = leave ? FLUSH : RUN;
        tick_nx = tick >= rate_div ? '0 : tick + 1'b1;
        fir_x_nx = take && s_valid ? s_data : '0;
      end
      FLUSH: begin
        state_nx = flush_cnt == CNT_W'(FLUSH_N - 1) ? IDLE : FLUSH;
        flush_cnt_nx = flush_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tick <= '0;
      flush_cnt <= '0;
      fir_x <= '0;
      vpipe <= '0;
    end else begin
      state <= state_nx;
      tick <= tick_nx;
      flush_cnt <= flush_cnt_nx;
      fir_x <= fir_x_nx;
      vpipe <= (vpipe << 1) | LATENCY'(state == RUN || state == FLUSH);
    end
  end
`ifdef FIR_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      underrun_cnt <= '0;
    else if (take && !s_valid && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer: scoreboard bench; the bench itself plays a unit-delay FIR.
module tb_fir_stream_sequencer;
  logic clk = 0, rst = 0, enable = 1, flush_req = 0, s_valid = 1;
  logic s_ready, m_valid, busy;
  logic [7:0] rate_div = 0, s_data = 100, fir_x, fir_y = 0, m_data;
`ifdef FIR_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic acc_prev = 0;

  fir_stream_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .rate_div(rate_div),
    .flush_req(flush_req), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .fir_x(fir_x), .fir_y(fir_y),
    .m_valid(m_valid), .m_data(m_data), .busy(busy)
`ifdef FIR_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) fir_y <= fir_x;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask

  task automatic at_pos;
    @(posedge clk);
    #1;
  endtask

  // accepted samples must appear on fir_x one edge later; every other cycle is a stuffed zero
  always @(negedge clk) begin
    if (acc_prev) chk("fir_x_sb", fir_x, exp_q.pop_front());
    else chk("fir_x_zero", fir_x, 0);
    chk("m_data", m_data, fir_y);
    acc_prev = s_valid && s_ready;
    if (acc_prev) exp_q.push_back(s_data);
  end

  initial begin
    int n, nr, nx, lim;
    repeat (5) begin
      at_neg;
      chk("rst_ready", s_ready, 0);
      chk("rst_x", fir_x, 0);
      chk("rst_mv", m_valid, 0);
      chk("rst_busy", busy, 0);
    end
    at_pos;
    rst = 1;
    at_neg;
    chk("idle_busy", busy, 0);
    at_neg;
    chk("run_busy", busy, 1);
    chk("run_ready", s_ready, 1);
    chk("run_mv0", m_valid, 0);
    at_neg;
    chk("run_x", fir_x, 100);
    chk("run_mv1", m_valid, 1);
    repeat (3) begin
      at_neg;
      chk("r0_ready", s_ready, 1);
      chk("r0_mdata", m_data, 100);
    end
    at_pos;
    rate_div = 3;
    s_data = 255;
    at_pos;
    nr = 0;
    nx = 0;
    repeat (8) begin
      at_neg;
      nr += int'(s_ready);
      nx += int'(fir_x == 255);
    end
    chk("r3_ready", nr, 2);
    chk("r3_x", nx, 2);
    at_pos;
    rate_div = 1;
    repeat (4) at_pos;
    nr = 0;
    nx = 0;
    repeat (8) begin
      at_neg;
      nr += int'(s_ready);
      nx += int'(fir_x == 255);
    end
    chk("r1_ready", nr, 4);
    chk("r1_x", nx, 4);
    at_pos;
    s_valid = 0;
    n = 0;
    lim = 0;
    while (n < 3 && lim < 40) begin
      at_neg;
      if (s_ready) n++;
      lim++;
    end
    chk("ur_strobes", n, 3);
    at_pos;
    chk("ur_x", fir_x, 0);
`ifdef FIR_UNDERRUN_CNT_EN
    chk("ur_cnt", underrun_cnt, 3);
`endif
    s_valid = 1;
    s_data = 50;
    lim = 0;
    do begin
      at_neg;
      lim++;
    end while (!s_ready && lim < 10);
    chk("ready_to", s_ready, 1);
    at_neg;
    chk("ur_x50", fir_x, 50);
`ifdef FIR_UNDERRUN_CNT_EN
    chk("ur_cnt_hold", underrun_cnt, 3);
`endif
    at_pos;
    s_data = 77;
    #1;
    chk("pre_flush_ready", s_ready, 1);
    flush_req = 1;
    #1;
    chk("flush_ready", s_ready, 0);
    at_pos;
    flush_req = 0;
    n = 0;
    at_neg;
    while (busy && n < 20) begin
      n++;
      chk("flush_x", fir_x, 0);
      at_neg;
    end
    chk("flush_len", n, 5);
    chk("mv_tail", m_valid, 1);
    at_neg;
    chk("mv_drop", m_valid, 0);
    at_pos;
    flush_req = 1;
    at_pos;
    flush_req = 0;
    at_pos;
    rst = 0;
    #1;
    chk("mid_rst_mv", m_valid, 0);
    chk("mid_rst_ready", s_ready, 0);
    at_pos;
    chk("mid_rst_x", fir_x, 0);
    chk("mid_rst_mv2", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1;
    rate_div = 2;
    s_data = 33;
    at_neg;
    chk("re_idle", busy, 0);
    at_neg;
    chk("re_busy", busy, 1);
    chk("re_t0", s_ready, 0);
    at_neg;
    chk("re_t1", s_ready, 0);
    at_neg;
    chk("re_t2", s_ready, 1);
    at_neg;
    chk("re_x", fir_x, 33);
    repeat (3) at_neg;
    chk("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
